// File: rtl/cla_nibble_seq_adder.sv
// cla_nibble_seq_adder
// Nibble-serial WIDTH-bit adder. Accepts one operand pair over a valid/ready
// handshake, adds one 4-bit nibble per clock (LSB nibble first) through a
// single 4-bit carry-lookahead slice, and presents the registered result over
// a valid/ready output handshake.
//
// Parameters:
//   WIDTH      operand/sum width, multiple of 4 and at least 4
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair on a/b/cin is valid
//   in_ready   block can accept an operand pair (IDLE only)
//   a, b       operands (unsigned or two's complement)
//   cin        carry into nibble 0
//   out_valid  result on sum/cout/overflow is valid (DONE only)
//   out_ready  consumer takes the result
//   sum        a + b + cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   overflow   signed overflow of the addition
module cla_nibble_seq_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    // Bit offset of the current nibble (counter * 4).
    logic [CNT_W+1:0]   w_shamt;
    logic [WIDTH-1:0]   w_a_sh;
    logic [WIDTH-1:0]   w_b_sh;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_g;
    logic [3:0]         w_p;
    logic [4:0]         w_c;
    logic [3:0]         w_nib_sum;
    logic [WIDTH-1:0]   w_nib_mask;
    logic [WIDTH-1:0]   w_nib_ins;
    logic [WIDTH-1:0]   w_sum_next;
    logic               w_ovf_next;

    // Nibble select
    assign w_shamt = {r_cnt, 2'b00};
    assign w_a_sh  = r_a >> w_shamt;
    assign w_b_sh  = r_b >> w_shamt;
    assign w_a_nib = w_a_sh[3:0];
    assign w_b_nib = w_b_sh[3:0];

    // 4-bit carry-lookahead slice
    assign w_g    = w_a_nib & w_b_nib;
    assign w_p    = w_a_nib ^ w_b_nib;
    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_nib_sum = w_p ^ w_c[3:0];

    // Merge the slice sum into the result register at the current nibble.
    assign w_nib_mask = WIDTH'(4'hF) << w_shamt;
    assign w_nib_ins  = WIDTH'(w_nib_sum) << w_shamt;
    assign w_sum_next = (r_sum & ~w_nib_mask) | w_nib_ins;

    // Only meaningful on the last nibble, where w_sum_next holds the full sum.
    assign w_ovf_next = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                        (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_c[4];
                    if (r_cnt == LAST_IDX) begin
                        r_cout  <= w_c[4];
                        r_ovf   <= w_ovf_next;
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

endmodule
